// File: rtl/gpio_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_arb_pkg
// Description : Shared types, defaults and helpers for the GPIO bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 1;

    // Read data returned to the master when the slave never releases waitrequest
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic is_req(input logic cs, input logic rd, input logic wr);
        return cs & (rd | wr);
    endfunction

    // A write strobe takes priority over a simultaneous read strobe
    function automatic logic is_read(input logic rd, input logic wr);
        return rd & ~wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bus_arbiter_if
// Description : Avalon-MM style link between a bus master and a bus slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_bus_arbiter_if #(
    parameter int DATA_W = gpio_arb_pkg::DEF_DATA_W,
    parameter int ADDR_W = gpio_arb_pkg::DEF_ADDR_W
);

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              write;
    logic              read;
    logic              chipselect;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address,
        output writedata,
        output write,
        output read,
        output chipselect,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  writedata,
        input  write,
        input  read,
        input  chipselect,
        output readdata,
        output waitrequest
    );

endinterface
`default_nettype wire

// File: rtl/gpio_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way combinational round-robin pick; ties go to the master
//               that was not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       gnt_o
);

    always_comb begin
        if (req_i == 2'b11) begin
            gnt_o = ~last_gnt_i;
        end else begin
            gnt_o = req_i[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bus_arbiter
// Description : Two-master round-robin arbiter in front of the GPIO register
//               slave; one transfer in flight, registered read data.
//               Optional slave-stall timeout enabled by macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               resetn,
    gpio_bus_arbiter_if.slave  m0,
    gpio_bus_arbiter_if.slave  m1,
    gpio_bus_arbiter_if.master s
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               arb_err
`endif
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_XFER = XFER;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              req0, req1, arb_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_wr, sel_rd;

    assign req0 = is_req(m0.chipselect, m0.read, m0.write);
    assign req1 = is_req(m1.chipselect, m1.read, m1.write);

    rr_arb2 u_rr_arb2 (
        .req_i      ({req1, req0}),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (arb_gnt)
    );

    always_comb begin
        sel_addr  = gnt_q ? m1.address   : m0.address;
        sel_wdata = gnt_q ? m1.writedata : m0.writedata;
        sel_wr    = gnt_q ? m1.write     : m0.write;
        sel_rd    = is_read(gnt_q ? m1.read : m0.read, sel_wr);
    end

    // Slave side is only live during XFER so the GPIO block sees clean idles
    always_comb begin
        s.chipselect = 1'b0;
        s.address    = '0;
        s.writedata  = '0;
        s.write      = 1'b0;
        s.read       = 1'b0;
        if (state_q == ST_XFER) begin
            s.chipselect = 1'b1;
            s.address    = sel_addr;
            s.writedata  = sel_wdata;
            s.write      = sel_wr;
            s.read       = sel_rd;
        end
    end

    assign m0.waitrequest = ~((state_q == ST_RESP) & ~gnt_q);
    assign m1.waitrequest = ~((state_q == ST_RESP) &  gnt_q);
    assign m0.readdata    = rdata_q;
    assign m1.readdata    = rdata_q;

`ifdef ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign arb_err = err_q;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        rdata_d    = rdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    gnt_d      = arb_gnt;
                    last_gnt_d = arb_gnt;
                    state_d    = ST_XFER;
`ifdef ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_XFER: begin
                if (!s.waitrequest) begin
                    if (sel_rd) begin
                        rdata_d = s.readdata;
                    end
                    state_d = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                // The stall cycle that brings the count to TIMEOUT aborts the transfer
                else if (cnt_q == CNT_LAST) begin
                    rdata_d = DATA_W'(TIMEOUT_DATA);
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            rdata_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            rdata_q    <= rdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_bus_arbiter
// Description : Directed scoreboard bench for gpio_bus_arbiter with a GPIO
//               slave model that can stall or stick waitrequest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_bus_arbiter;
    import gpio_arb_pkg::*;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    gpio_bus_arbiter_if m0_if ();
    gpio_bus_arbiter_if m1_if ();
    gpio_bus_arbiter_if s_if ();
`ifdef ARB_TIMEOUT_EN
    logic arb_err;
`endif

    gpio_bus_arbiter #(
        .DATA_W  (32),
        .ADDR_W  (1),
        .TIMEOUT (15)
    ) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if)
`ifdef ARB_TIMEOUT_EN
        ,
        .arb_err(arb_err)
`endif
    );

    // GPIO slave model: waitrequest held for stall_cfg cycles, or forever when stuck
    logic [31:0] smem [2] = '{32'h0, 32'hA5A5_0003};
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    bit          stuck     = 1'b0;

    assign s_if.waitrequest = s_if.chipselect && (stuck || (stall_cnt < stall_cfg));
    assign s_if.readdata    = smem[s_if.address];

    always @(posedge clock) begin
        if (!s_if.chipselect) begin
            stall_cnt <= 0;
        end else if (s_if.waitrequest) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt <= 0;
            if (s_if.write) smem[s_if.address] <= s_if.writedata;
        end
    end

    typedef struct {
        int          m;
        logic [31:0] rd;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_mem [2] = '{32'h0, 32'hA5A5_0003};
    logic [31:0] exp_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, {31'h0, obs}, {31'h0, exp});
    endtask

    task automatic chk_wait(input string tag, input logic w0, input logic w1);
        chkb({tag, "_m0_wait"}, m0_if.waitrequest, w0);
        chkb({tag, "_m1_wait"}, m1_if.waitrequest, w1);
    endtask

    task automatic sb_pop(input int m, input logic [31:0] rd);
        exp_t e;
        chkb("sb_pending", sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_master", 32'(m), 32'(e.m));
            chk("sb_rdata", rd, e.rd);
        end
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (!m0_if.waitrequest) sb_pop(0, m0_if.readdata);
            if (!m1_if.waitrequest) sb_pop(1, m1_if.readdata);
        end
    end

    task automatic expect_done(input int m, input bit wr, input logic a, input logic [31:0] d);
        exp_t e;
        if (wr) exp_mem[a] = d;
        else    exp_rd     = exp_mem[a];
        e.m  = m;
        e.rd = exp_rd;
        sbq.push_back(e);
    endtask

    task automatic drive(input int m, input bit wr, input bit rd, input logic a, input logic [31:0] d);
        if (m == 0) begin
            m0_if.chipselect = 1'b1; m0_if.write = wr; m0_if.read = rd;
            m0_if.address = a; m0_if.writedata = d;
        end else begin
            m1_if.chipselect = 1'b1; m1_if.write = wr; m1_if.read = rd;
            m1_if.address = a; m1_if.writedata = d;
        end
    endtask

    task automatic release_m(input int m);
        if (m == 0) begin
            m0_if.chipselect = 1'b0; m0_if.write = 1'b0; m0_if.read = 1'b0;
            m0_if.address = 1'b0; m0_if.writedata = 32'h0;
        end else begin
            m1_if.chipselect = 1'b0; m1_if.write = 1'b0; m1_if.read = 1'b0;
            m1_if.address = 1'b0; m1_if.writedata = 32'h0;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        release_m(0);
        release_m(1);
        repeat (2) @(negedge clock);
        chk_wait("rst", 1'b1, 1'b1);
        chk("rst_m0_rdata", m0_if.readdata, 32'h0);
        chk("rst_m1_rdata", m1_if.readdata, 32'h0);
        chkb("rst_s_cs", s_if.chipselect, 1'b0);
        chkb("rst_s_write", s_if.write, 1'b0);
        chkb("rst_s_read", s_if.read, 1'b0);
`ifdef ARB_TIMEOUT_EN
        chkb("rst_arb_err", arb_err, 1'b0);
`endif
        resetn = 1'b1;
        exp_rd = 32'h0;
    endtask

    // One isolated transfer starting in an IDLE cycle (cycle 0)
    task automatic single(input int m, input bit wr, input bit rd, input logic a,
                          input logic [31:0] d, input int stall);
        stall_cfg = stall;
        expect_done(m, wr, a, d);
        drive(m, wr, rd, a, d);
        chkb("idle_s_cs", s_if.chipselect, 1'b0);
        for (int k = 1; k <= stall + 1; k++) begin
            @(negedge clock);
            chkb("xfer_cs", s_if.chipselect, 1'b1);
            chkb("xfer_write", s_if.write, wr);
            chkb("xfer_read", s_if.read, rd & ~wr);
            chkb("xfer_addr", s_if.address, a);
            chk("xfer_wdata", s_if.writedata, d);
            chk_wait("xfer", 1'b1, 1'b1);
        end
        @(negedge clock);
        chk_wait("resp", m != 0, m == 0);
        chk("resp_rdata", (m == 0) ? m0_if.readdata : m1_if.readdata, exp_rd);
        release_m(m);
        @(negedge clock);
        chk_wait("after", 1'b1, 1'b1);
        chkb("after_s_cs", s_if.chipselect, 1'b0);
        chk("held_rdata", (m == 0) ? m0_if.readdata : m1_if.readdata, exp_rd);
    endtask

    initial begin
        int n;
        do_reset();

        single(0, 1'b1, 1'b0, 1'b0, 32'h0000_00FF, 0);
        single(1, 1'b0, 1'b1, 1'b1, 32'h0, 0);
        single(0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 0);
        single(1, 1'b0, 1'b1, 1'b0, 32'h0, 3);

        // Both masters request continuously from reset: m0, m1, m0, m1
        do_reset();
        stall_cfg = 0;
        expect_done(0, 1'b1, 1'b0, 32'h11);
        expect_done(1, 1'b0, 1'b1, 32'h0);
        expect_done(0, 1'b1, 1'b0, 32'h11);
        expect_done(1, 1'b0, 1'b1, 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h11);
        drive(1, 1'b0, 1'b1, 1'b1, 32'h0);
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) @(negedge clock);
            chk_wait("rr", !(k == 2 || k == 8), !(k == 5 || k == 11));
        end
        release_m(0);
        release_m(1);
        @(negedge clock);

        single(0, 1'b0, 1'b1, 1'b0, 32'h0, 1);

`ifdef ARB_TIMEOUT_EN
        stuck = 1'b1;
        begin
            exp_t e;
            exp_rd = TIMEOUT_DATA;
            e.m    = 0;
            e.rd   = exp_rd;
            sbq.push_back(e);
        end
        drive(0, 1'b0, 1'b1, 1'b0, 32'h0);
        n = 0;
        while (m0_if.waitrequest && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("to_cycle", 32'(n), 32'd16);
        chk("to_rdata", m0_if.readdata, 32'hDEAD_BEEF);
        chkb("to_arb_err", arb_err, 1'b1);
        release_m(0);
        stuck = 1'b0;
        @(negedge clock);
        chkb("to_err_sticky", arb_err, 1'b1);
`endif

        // Reset in the middle of a stalled transfer: no completion afterwards
        stall_cfg = 5;
        drive(1, 1'b0, 1'b1, 1'b1, 32'h0);
        repeat (2) @(negedge clock);
        chkb("mid_xfer_cs", s_if.chipselect, 1'b1);
        resetn = 1'b0;
        release_m(1);
        @(negedge clock);
        chk_wait("mid_rst", 1'b1, 1'b1);
        chkb("mid_rst_cs", s_if.chipselect, 1'b0);
        chk("mid_rst_rdata", m1_if.readdata, 32'h0);
`ifdef ARB_TIMEOUT_EN
        chkb("mid_rst_err", arb_err, 1'b0);
`endif
        resetn = 1'b1;
        exp_rd = 32'h0;
        n = 0;
        repeat (6) begin
            @(negedge clock);
            n += {31'h0, ~m0_if.waitrequest} + {31'h0, ~m1_if.waitrequest} + {31'h0, s_if.chipselect};
        end
        chk("post_rst_activity", 32'(n), 32'd0);
        stall_cfg = 0;

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/gpio_bus_arbiter.md
Name: gpio_bus_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares one GPIO register slave (DDR/POUT/PIN block) between master 0 (CPU data port) and master 1 (debug/DMA port).
- Round-robin grant and one transaction in flight at a time.
- Read data is registered back to the winning master.
- Sits between the system interconnect and the GPIO slave.

Parameters:
- DATA_W, 32, data width of all read/write data buses.
- ADDR_W, 1, slave word address width.
- TIMEOUT, 15, max cycles the slave may hold s_waitrequest before the transfer is aborted (only used with ARB_TIMEOUT_EN).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- resetn  in  1  reset; synchronous, active-low.
- mN_address  in  ADDR_W  master N word address (N = 0,1).
- mN_writedata  in  DATA_W  master N write data.
- mN_write  in  1  master N write strobe.
- mN_read  in  1  master N read strobe.
- mN_chipselect  in  1  master N select.
- mN_readdata  out  DATA_W  registered read data to master N.
- mN_waitrequest  out  1  master N stall.
- s_address  out  ADDR_W  to GPIO slave.
- s_writedata  out  DATA_W  to GPIO slave.
- s_write  out  1  to GPIO slave.
- s_read  out  1  to GPIO slave.
- s_chipselect  out  1  to GPIO slave.
- s_readdata  in  DATA_W  from GPIO slave, valid in the cycle s_waitrequest=0.
- s_waitrequest  in  1  from GPIO slave.

Behaviour:
- Request definition: reqN = mN_chipselect & (mN_read | mN_write). If read and write are both high, it is a write and the read is ignored. Masters hold all signals stable while mN_waitrequest=1.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick winner, register gnt, go to XFER.
  - Winner rule: single requester wins. With both requesting, the master != last_gnt wins.
  - last_gnt updates at each grant.
- XFER:
  - s_* driven combinationally from master gnt's inputs; s_chipselect=1.
  - When s_waitrequest=0: capture s_readdata into rdata_q (reads only; writes leave rdata_q unchanged) and go to RESP.
  - Otherwise stay in XFER.
- RESP:
  - mN_waitrequest=0 for master gnt only, for exactly one cycle; mN_readdata=rdata_q.
  - Return to IDLE. No back-to-back grant from RESP, so there is one idle bubble per transaction.
- Latency: a request presented in cycle 0 completes (waitrequest low) in cycle 2 against a zero-wait slave.
- Outside XFER: all s_* outputs are 0.
- mN_waitrequest is 1 except for the granted master in RESP.
- Non-granted master: held with waitrequest=1 and served on the next IDLE.
- Reset (resetn=0 at a clock edge): state=IDLE, last_gnt=1 (master 0 wins first tie), gnt=0, rdata_q=0.
  - Resulting outputs: both mN_readdata=0, both mN_waitrequest=1, all s_* = 0.
- Reset mid-transfer: the transfer is dropped and no completion is signalled. A slave write already issued in XFER with s_waitrequest=0 at that edge has taken effect.
- Request withdrawn during XFER: protocol violation, behaviour undefined. The bench must not do this.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to XFER and increments each XFER cycle with s_waitrequest=1.
  - When the counter reaches TIMEOUT, XFER aborts to RESP with rdata_q=TIMEOUT_DATA (32'hDEAD_BEEF).
  - Sticky bit err_q sets; it is exposed on extra output port arb_err (1 bit) and cleared only by reset.
- Undefined: no counter, no arb_err port; XFER waits indefinitely.

Decomposition:
- Package gpio_arb_pkg:
  - state enum arb_state_t {IDLE, XFER, RESP}.
  - TIMEOUT_DATA constant.
  - Default DATA_W and ADDR_W localparams.
- One natural sub-module: rr_arb2.
  - Inputs: req[1:0], last_gnt.
  - Output: gnt index.
  - Purely combinational, reused by the top FSM.

Test Plan:
- Reset: after resetn low 2 cycles, both mN_waitrequest=1, both mN_readdata=0, s_chipselect=0.
- Single write: m0 writes addr 0, data 32'h0000_00FF at cycle 0 -> s_write=1 with s_writedata=32'h0000_00FF in cycle 1; m0_waitrequest=0 in cycle 2; m1_waitrequest stays 1 throughout.
- Read: slave returns 32'hA5A5_0003 at addr 1 -> m1 read gives m1_readdata=32'hA5A5_0003 in its RESP cycle; the value is held afterwards.
- Simultaneous requests from reset:
  - m0 is granted first and completes in cycle 2.
  - m1 completes in cycle 5.
  - Repeated simultaneous traffic alternates m1, m0, m1, and so on.
- Slave stall: s_waitrequest held 3 cycles -> XFER lasts 4 cycles and the master completes in cycle 5.
- Timeout (ARB_TIMEOUT_EN): s_waitrequest stuck high -> after 15 stall cycles the master completes with readdata=32'hDEAD_BEEF and arb_err=1. Asserting resetn low mid-XFER instead returns to IDLE with no completion.
